executor: RTL and testbench

EXECUTOR -- requirements
Module: executor

---
 rtl/pipeline_pkg.sv | 28 ++
 rtl/mul_seq.sv | 62 ++++++
 rtl/executor.sv | 149 ++++++++++++++
 tb/tb_executor.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared definitions for the execute stage: size defaults, opcode values and the
// executor FSM encoding.
package pipeline_pkg;

    localparam int WORD_SIZE_DEFAULT = 16;
    localparam int ADDR_SIZE_DEFAULT = 5;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_SHL = 4'd5;
    localparam logic [3:0] OP_SHR = 4'd6;
    localparam logic [3:0] OP_MUL = 4'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } exec_state_t;

    // Opcodes below MUL complete in the cycle after acceptance; 8-15 are NOPs.
    function automatic logic is_single_cycle(input logic [3:0] op);
        return op < OP_MUL;
    endfunction

endpackage

// File: rtl/mul_seq.sv
// Sequential shift-add multiplier: one partial product per cycle, WIDTH cycles
// per multiply. done pulses alongside the final product.
module mul_seq
    import pipeline_pkg::*;
#(
    parameter int WIDTH = WORD_SIZE_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH);

    logic               running;
    logic [CW-1:0]      count;
    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]   mplier;

    // The product leaves combinationally so the last iteration lands directly in
    // the executor's writeback registers.
    always_comb begin
        acc_next = acc;
        if (mplier[0]) begin
            acc_next = acc + mcand;
        end
    end

    assign done    = running && (count == CW'(WIDTH - 1));
    assign product = acc_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            running <= 1'b0;
            count   <= '0;
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
        end else if (start) begin
            running <= 1'b1;
            count   <= '0;
            acc     <= '0;
            mcand   <= {{WIDTH{1'b0}}, a};
            mplier  <= b;
        end else if (running) begin
            acc     <= acc_next;
            mcand   <= mcand << 1;
            mplier  <= mplier >> 1;
            count   <= count + CW'(1);
            if (done) begin
                running <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/executor.sv
// Execute stage: single-cycle ALU with writeback forwarding, plus a multi-cycle
// multiply sequenced by a small IDLE/MUL/DONE FSM.
module executor
    import pipeline_pkg::*;
#(
    parameter int WORD_SIZE = WORD_SIZE_DEFAULT,
    parameter int ADDR_SIZE = ADDR_SIZE_DEFAULT
) (
    input  logic                 i_CLK,
    input  logic                 i_RST,
    input  logic                 i_valid,
    input  logic [3:0]           i_opcode,
    input  logic [WORD_SIZE-1:0] i_pipedata_A,
    input  logic [WORD_SIZE-1:0] i_pipedata_B,
    input  logic [ADDR_SIZE-1:0] i_pipeaddr_A,
    input  logic [ADDR_SIZE-1:0] i_pipeaddr_B,
    input  logic [ADDR_SIZE-1:0] i_wraddr,
    output logic                 o_busy,
    output logic                 o_wren,
    output logic [WORD_SIZE-1:0] o_result,
    output logic [ADDR_SIZE-1:0] o_wraddr,
    output logic                 o_flag_zero,
    output logic                 o_flag_carry
);

    localparam int SHIFT_W = $clog2(WORD_SIZE);

    exec_state_t state, state_next;

    logic                   accept;
    logic [WORD_SIZE-1:0]   op_a, op_b;
    logic [WORD_SIZE:0]     sum, diff;
    logic [WORD_SIZE-1:0]   alu_result;
    logic                   alu_carry;
    logic                   mul_start, mul_done;
    logic [2*WORD_SIZE-1:0] mul_product;
    logic [ADDR_SIZE-1:0]   mul_dest;
    logic                   busy_next, wren_next, zero_next, carry_next;
    logic [WORD_SIZE-1:0]   result_next;
    logic [ADDR_SIZE-1:0]   wraddr_next;

    assign accept = i_valid && !o_busy;

    // A result being written back this cycle has not reached the register file
    // yet, so it overrides the stale operand read upstream.
    assign op_a = (o_wren && (o_wraddr == i_pipeaddr_A)) ? o_result : i_pipedata_A;
    assign op_b = (o_wren && (o_wraddr == i_pipeaddr_B)) ? o_result : i_pipedata_B;

    assign sum  = {1'b0, op_a} + {1'b0, op_b};
    assign diff = {1'b0, op_a} - {1'b0, op_b};

    always_comb begin
        alu_result = '0;
        alu_carry  = 1'b0;
        case (i_opcode)
            OP_ADD: begin
                alu_result = sum[WORD_SIZE-1:0];
                alu_carry  = sum[WORD_SIZE];
            end
            OP_SUB: begin
                alu_result = diff[WORD_SIZE-1:0];
                alu_carry  = diff[WORD_SIZE];
            end
            OP_AND:  alu_result = op_a & op_b;
            OP_OR:   alu_result = op_a | op_b;
            OP_XOR:  alu_result = op_a ^ op_b;
            OP_SHL:  alu_result = op_a << op_b[SHIFT_W-1:0];
            OP_SHR:  alu_result = op_a >> op_b[SHIFT_W-1:0];
            default: ;
        endcase
    end

    mul_seq #(
        .WIDTH(WORD_SIZE)
    ) u_mul (
        .clk    (i_CLK),
        .reset  (i_RST),
        .start  (mul_start),
        .a      (op_a),
        .b      (op_b),
        .done   (mul_done),
        .product(mul_product)
    );

    // DONE behaves like IDLE for acceptance, which gives back-to-back issue
    // straight after a multiply completes.
    always_comb begin
        state_next  = state;
        wren_next   = 1'b0;
        result_next = o_result;
        wraddr_next = o_wraddr;
        zero_next   = o_flag_zero;
        carry_next  = o_flag_carry;
        mul_start   = 1'b0;
        case (state)
            ST_MUL: begin
                if (mul_done) begin
                    state_next  = ST_DONE;
                    wren_next   = 1'b1;
                    result_next = mul_product[WORD_SIZE-1:0];
                    wraddr_next = mul_dest;
                    zero_next   = (mul_product[WORD_SIZE-1:0] == '0);
                    carry_next  = |mul_product[2*WORD_SIZE-1:WORD_SIZE];
                end
            end
            default: begin
                state_next = ST_IDLE;
                if (accept) begin
                    if (is_single_cycle(i_opcode)) begin
                        wren_next   = 1'b1;
                        result_next = alu_result;
                        wraddr_next = i_wraddr;
                        zero_next   = (alu_result == '0);
                        carry_next  = alu_carry;
                    end else if (i_opcode == OP_MUL) begin
                        mul_start  = 1'b1;
                        state_next = ST_MUL;
                    end
                end
            end
        endcase
        busy_next = (state_next == ST_MUL);
    end

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            state        <= ST_IDLE;
            o_busy       <= 1'b0;
            o_wren       <= 1'b0;
            o_result     <= '0;
            o_wraddr     <= '0;
            o_flag_zero  <= 1'b0;
            o_flag_carry <= 1'b0;
            mul_dest     <= '0;
        end else begin
            state        <= state_next;
            o_busy       <= busy_next;
            o_wren       <= wren_next;
            o_result     <= result_next;
            o_wraddr     <= wraddr_next;
            o_flag_zero  <= zero_next;
            o_flag_carry <= carry_next;
            if (mul_start) begin
                mul_dest <= i_wraddr;
            end
        end
    end

endmodule

// File: tb/tb_executor.sv
// Randomized scoreboard bench for executor: a transaction-level model predicts
// writebacks, busy and flags; a monitor pops expectations on every o_wren.
module tb_executor;

    localparam int WS         = 16;
    localparam int AS         = 5;
    localparam int MUL_CYCLES = 16;

    logic          clk = 1'b0;
    logic          i_RST, i_valid;
    logic [3:0]    i_opcode;
    logic [WS-1:0] i_pipedata_A, i_pipedata_B;
    logic [AS-1:0] i_pipeaddr_A, i_pipeaddr_B, i_wraddr;
    logic          o_busy, o_wren, o_flag_zero, o_flag_carry;
    logic [WS-1:0] o_result;
    logic [AS-1:0] o_wraddr;

    executor #(
        .WORD_SIZE(WS),
        .ADDR_SIZE(AS)
    ) dut (
        .i_CLK       (clk),
        .i_RST       (i_RST),
        .i_valid     (i_valid),
        .i_opcode    (i_opcode),
        .i_pipedata_A(i_pipedata_A),
        .i_pipedata_B(i_pipedata_B),
        .i_pipeaddr_A(i_pipeaddr_A),
        .i_pipeaddr_B(i_pipeaddr_B),
        .i_wraddr    (i_wraddr),
        .o_busy      (o_busy),
        .o_wren      (o_wren),
        .o_result    (o_result),
        .o_wraddr    (o_wraddr),
        .o_flag_zero (o_flag_zero),
        .o_flag_carry(o_flag_carry)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            cyc;
        logic [AS-1:0] addr;
        logic [WS-1:0] data;
        logic          zero;
        logic          carry;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    // Model of what the DUT should show in the current cycle.
    logic          m_busy, m_wren, m_zero, m_carry;
    logic [WS-1:0] m_res;
    logic [AS-1:0] m_addr;
    int            mul_left;
    logic [WS-1:0] pend_res;
    logic [AS-1:0] pend_addr;
    logic          pend_carry;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic checkCycle();
        checkOutput("busy",   32'(o_busy),       32'(m_busy));
        checkOutput("wren",   32'(o_wren),       32'(m_wren));
        checkOutput("result", 32'(o_result),     32'(m_res));
        checkOutput("wraddr", 32'(o_wraddr),     32'(m_addr));
        checkOutput("zero",   32'(o_flag_zero),  32'(m_zero));
        checkOutput("carry",  32'(o_flag_carry), 32'(m_carry));
    endtask

    // One cycle: check outputs, drive inputs, advance the model, step the clock.
    task automatic applyStimulus(input logic rst, input logic v, input logic [3:0] op,
                                 input logic [WS-1:0] da, input logic [WS-1:0] db,
                                 input logic [AS-1:0] pa, input logic [AS-1:0] pb,
                                 input logic [AS-1:0] wa);
        logic [WS-1:0] a, b, r;
        logic          c, accepted;
        int unsigned   ua, ub, full;
        exp_t          e;
        checkCycle();
        i_RST        = rst;
        i_valid      = v;
        i_opcode     = op;
        i_pipedata_A = da;
        i_pipedata_B = db;
        i_pipeaddr_A = pa;
        i_pipeaddr_B = pb;
        i_wraddr     = wa;
        accepted = !rst && v && !m_busy;
        a  = (m_wren && m_addr == pa) ? m_res : da;
        b  = (m_wren && m_addr == pb) ? m_res : db;
        ua = a;
        ub = b;
        r  = '0;
        c  = 1'b0;
        if (rst) begin
            m_busy = 0; m_wren = 0; m_res = 0; m_addr = 0;
            m_zero = 0; m_carry = 0; mul_left = 0;
        end else begin
            m_wren = 0;
            if (mul_left > 0) begin
                mul_left--;
                if (mul_left == 0) begin
                    m_wren = 1; m_res = pend_res; m_addr = pend_addr;
                    m_zero = (pend_res == 0); m_carry = pend_carry;
                    e.cyc = cyc + 1; e.addr = pend_addr; e.data = pend_res;
                    e.zero = m_zero; e.carry = m_carry;
                    sbq.push_back(e);
                end
            end
            if (accepted && op <= 4'd6) begin
                case (op)
                    4'd0: begin full = ua + ub; r = WS'(full); c = (full > 32'hFFFF); end
                    4'd1: begin r = WS'(ua - ub); c = (ua < ub); end
                    4'd2: r = a & b;
                    4'd3: r = a | b;
                    4'd4: r = a ^ b;
                    4'd5: r = WS'(ua << (ub % WS));
                    default: r = WS'(ua >> (ub % WS));
                endcase
                m_wren = 1; m_res = r; m_addr = wa; m_zero = (r == 0); m_carry = c;
                e.cyc = cyc + 1; e.addr = wa; e.data = r; e.zero = m_zero; e.carry = c;
                sbq.push_back(e);
            end else if (accepted && op == 4'd7) begin
                full       = ua * ub;
                pend_res   = WS'(full);
                pend_carry = ((full >> WS) != 0);
                pend_addr  = wa;
                mul_left   = MUL_CYCLES;
            end
            m_busy = (mul_left > 0);
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [WS-1:0] rdata();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return WS'($urandom_range(0, 15));
            default: return WS'($urandom);
        endcase
    endfunction

    task automatic idle(input int n);
        repeat (n) applyStimulus(1'b0, 1'b0, 4'($urandom), rdata(), rdata(),
                                 AS'($urandom), AS'($urandom), AS'($urandom));
    endtask

    task automatic resetFor(input int n);
        repeat (n) applyStimulus(1'b1, 1'($urandom), 4'($urandom), rdata(), rdata(),
                                 AS'($urandom), AS'($urandom), AS'($urandom));
    endtask

    // Holds the operation with valid high until the model says it is taken.
    task automatic issueOp(input logic [3:0] op, input logic [WS-1:0] da, input logic [WS-1:0] db,
                           input logic [AS-1:0] pa, input logic [AS-1:0] pb, input logic [AS-1:0] wa);
        logic was_free;
        do begin
            was_free = !m_busy;
            applyStimulus(1'b0, 1'b1, op, da, db, pa, pb, wa);
        end while (!was_free);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (o_wren === 1'b1) begin
                checkOutput("wb_pending", 32'(sbq.size() > 0), 32'd1);
                if (sbq.size() > 0) begin
                    e = sbq.pop_front();
                    checkOutput("wb_cycle", 32'(cyc),          32'(e.cyc));
                    checkOutput("wb_addr",  32'(o_wraddr),     32'(e.addr));
                    checkOutput("wb_data",  32'(o_result),     32'(e.data));
                    checkOutput("wb_zero",  32'(o_flag_zero),  32'(e.zero));
                    checkOutput("wb_carry", 32'(o_flag_carry), 32'(e.carry));
                end
            end
        end
    end

    initial begin : driver
        logic [3:0] op;
        i_RST = 1'b1; i_valid = 1'b0; i_opcode = '0;
        i_pipedata_A = '0; i_pipedata_B = '0;
        i_pipeaddr_A = '0; i_pipeaddr_B = '0; i_wraddr = '0;
        m_busy = 0; m_wren = 0; m_res = '0; m_addr = '0; m_zero = 0; m_carry = 0;
        mul_left = 0; pend_res = '0; pend_addr = '0; pend_carry = 0;
        @(posedge clk);
        #1;
        resetFor(2);

        issueOp(4'd0, 16'h0005, 16'h0003, 5'd1, 5'd2, 5'd4);
        issueOp(4'd0, 16'hFFFF, 16'h0001, 5'd1, 5'd2, 5'd5);
        issueOp(4'd1, 16'h0002, 16'h0003, 5'd1, 5'd2, 5'd6);
        idle(1);
        issueOp(4'd7, 16'h0100, 16'h0200, 5'd1, 5'd2, 5'd8);
        issueOp(4'd7, 16'h0012, 16'h0003, 5'd1, 5'd2, 5'd9);
        issueOp(4'd0, 16'h1234, 16'h0101, 5'd1, 5'd2, 5'd7);
        issueOp(4'd4, 16'hAAAA, 16'h5555, 5'd7, 5'd7, 5'd10);
        idle(2);
        issueOp(4'hA, 16'h0001, 16'h0001, 5'd1, 5'd2, 5'd3);
        issueOp(4'd0, 16'h0001, 16'h0001, 5'd1, 5'd2, 5'd3);
        idle(1);
        issueOp(4'd7, 16'h00FF, 16'h00FF, 5'd1, 5'd2, 5'd11);
        idle(4);
        resetFor(1);
        idle(20);

        for (int i = 0; i < 500; i++) begin
            op = 4'($urandom);
            if ($urandom_range(0, 99) == 0) begin
                resetFor(1);
            end else begin
                applyStimulus(1'b0, 1'($urandom_range(0, 2) != 0), op, rdata(), rdata(),
                              AS'($urandom_range(0, 3)), AS'($urandom_range(0, 3)),
                              AS'($urandom_range(0, 3)));
            end
        end

        idle(MUL_CYCLES + 4);
        checkOutput("scoreboard_empty", 32'(sbq.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
